// File: rtl/trig_sched.sv
`default_nettype none
// ============================================================================
// Module   : trig_sched
// Purpose  : Round-robin scheduler sharing one trigger stage between N_REQ
//            requesters, with a fixed pulse window and a programmable guard gap.
// Revision : 1.0 - initial release
// ============================================================================
module trig_sched #(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 8,
    parameter int PULSE_LEN = 2,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [CNT_W-1:0] period,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  cur_id,
    output logic             trig_ena,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    localparam logic [CNT_W-1:0] c_pulse_init = CNT_W'(PULSE_LEN - 1);
    localparam logic [ID_W-1:0]  c_last_id    = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    c_n_req      = (ID_W + 1)'(N_REQ);

    logic [1:0]       r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [ID_W-1:0]  r_ptr,    w_ptr_nxt;
    logic [N_REQ-1:0] r_gnt,    w_gnt_nxt;
    logic [ID_W-1:0]  r_cur_id, w_cur_id_nxt;
    logic             r_trig,   w_trig_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_busy,   w_busy_nxt;

    // Rotate so the pointer position sits at bit 0; the lowest set bit is the winner's offset.
    logic [2*N_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_winner;

    assign w_rot = {req, req} >> r_ptr;

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = ID_W'(i);
        end
    end

    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_n_req) w_sum = w_sum - c_n_req;
        w_winner = w_sum[ID_W-1:0];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_gnt_nxt    = r_gnt;
        w_cur_id_nxt = r_cur_id;
        w_trig_nxt   = r_trig;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en && |req) begin
                    w_gnt_nxt    = N_REQ'(1) << w_winner;
                    w_cur_id_nxt = w_winner;
                    w_trig_nxt   = 1'b1;
                    w_cnt_nxt    = c_pulse_init;
                    w_state_nxt  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!en) begin
                    // Abort: no completion, pointer and cur_id are left alone.
                    w_gnt_nxt   = '0;
                    w_trig_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_gnt_nxt  = '0;
                    w_trig_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_ptr_nxt  = (r_cur_id == c_last_id) ? '0 : r_cur_id + 1'b1;
                    if (period == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = period - 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_trig_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_cur_id <= '0;
            r_trig   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_cur_id <= w_cur_id_nxt;
            r_trig   <= w_trig_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign cur_id   = r_cur_id;
    assign trig_ena = r_trig;
    assign done     = r_done;
    assign busy     = r_busy;

endmodule
`default_nettype wire
